membus_arbiter: RTL

- Two-requester arbiter for the SoC native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Shares one downstream bus between requester 0 (CPU core) and requester 1 (DMA/debug master).
- Downstream targets are RAM, SPI flash, UART/config registers and iomem.
- Round-robin grant, held for the whole transaction, with a bus-timeout watchdog so a dead slave cannot hang either master.

---
 rtl/soc_bus_pkg.sv | 20 ++
 rtl/membus_timeout_ctr.sv | 31 +++
 rtl/membus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC native memory bus: arbiter state encoding,
// the bus error word and the address-map constants used by the bus fabric.
package soc_bus_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } bus_state_e;

    // Returned to a master whose transaction was forcibly completed.
    localparam logic [31:0] BusErrWord = 32'hFFFF_FFFF;

    localparam logic [31:0] RamLimit = 32'h0002_0000;
    localparam logic [31:0] CfgBase  = 32'h0200_0000;

    function automatic logic is_cfg_addr(input logic [31:0] addr);
        return addr[31:24] == CfgBase[31:24];
    endfunction

endpackage

// File: rtl/membus_timeout_ctr.sv
// Bus watchdog counter: counts enabled cycles and flags the terminal count
// (TERMINAL-1) so the owner can force a completion on that same cycle.
module membus_timeout_ctr #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TERMINAL + 1);
    localparam logic [CntW-1:0] LastVal = CntW'(TERMINAL - 1);

    logic [CntW-1:0] cnt_q;

    // Holds at the terminal value rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LastVal)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == LastVal);

endmodule

// File: rtl/membus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus. Grant is held for
// a whole transaction; a watchdog forces an error completion on a dead slave.
module membus_arbiter
    import soc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RESET_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    bus_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        gnt_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        ctr_clear, ctr_enable, ctr_expire;

    membus_timeout_ctr #(
        .TERMINAL(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .enable(ctr_enable),
        .expire(ctr_expire)
    );

    assign gnt_valid = grant_q ? m1_valid : m0_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= RESET_PRIO;
            // Pretend the other master was served last so RESET_PRIO wins a tie.
            last_q  <= ~RESET_PRIO;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        ctr_clear   = 1'b0;
        ctr_enable  = 1'b0;
        rsp_ready   = 1'b0;
        rsp_data    = s_rdata;
        timeout_err = 1'b0;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;

        unique case (state_q)
            StIdle: begin
                ctr_clear = 1'b1;
                if (m0_valid || m1_valid) begin
                    state_d = StBusy;
                    if (m0_valid && m1_valid) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = m1_valid;
                    end
                end
            end
            StBusy: begin
                s_valid = gnt_valid;
                if (gnt_valid) begin
                    s_instr = grant_q ? m1_instr : m0_instr;
                    s_addr  = grant_q ? m1_addr  : m0_addr;
                    s_wdata = grant_q ? m1_wdata : m0_wdata;
                    s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
                end
                if (!gnt_valid) begin
                    // Owner withdrew: drop the transaction silently.
                    state_d   = StIdle;
                    ctr_clear = 1'b1;
                end else if (s_ready) begin
                    rsp_ready = 1'b1;
                    last_d    = grant_q;
                    state_d   = StIdle;
                    ctr_clear = 1'b1;
                end else if (ctr_expire) begin
                    rsp_ready   = 1'b1;
                    rsp_data    = BusErrWord;
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                    ctr_clear   = 1'b1;
                end else begin
                    ctr_enable = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (state_q == StBusy) begin
            if (grant_q) begin
                m1_ready = rsp_ready;
                m1_rdata = rsp_data;
            end else begin
                m0_ready = rsp_ready;
                m0_rdata = rsp_data;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == StBusy);

endmodule
